// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared types and constants for the bit-serial add/subtract sequencer.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Same encoding as the func input of the 1-bit full adder/subtractor cell.
  localparam logic FUNC_ADD = 1'b1;
  localparam logic FUNC_SUB = 1'b0;

endpackage

// File: rtl/serial_addsub_ctrl_if.sv
// Operand and result bundles for the serial add/subtract sequencer.
//
// Both bundles use valid/ready: the producer raises valid with stable payload
// and holds it until the edge on which valid && ready, which is the only
// edge where a transfer happens; ready may be raised or dropped at any time.
interface serial_addsub_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_func;
  logic             result_valid;
  logic             result_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start_valid, op_a, op_b, op_func, result_ready,
    input  start_ready, result_valid, result, carry_out, overflow
  );

  modport slave (
    input  start_valid, op_a, op_b, op_func, result_ready,
    output start_ready, result_valid, result, carry_out, overflow
  );
endinterface

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial sequencer driving an external 1-bit full adder/subtractor cell,
// LSB first, with the cell's carry/borrow fed back through a register.
module serial_addsub_ctrl
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic   clk,
  input  logic   rst,
  serial_addsub_ctrl_if.slave bus,
  output logic   cell_func,
  output logic   cell_in1,
  output logic   cell_in2,
  output logic   cell_in3,
  input  logic   cell_sum,
  input  logic   cell_cob,
  output state_t state_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] res_sh_q;
  logic             func_q;
  logic             cob_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             ovf_q;
  logic             run;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      func_q   <= FUNC_SUB;
      cob_q    <= 1'b0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_valid) begin
            a_sh_q  <= bus.op_a;
            b_sh_q  <= bus.op_b;
            func_q  <= bus.op_func;
            cob_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
          res_sh_q <= {cell_sum, res_sh_q[WIDTH-1:1]};
          cob_q    <= cell_cob;
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            carry_q <= cell_cob;
            // Carry/borrow into the MSB differs from the one out of it on signed overflow.
            ovf_q   <= cob_q ^ cell_cob;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (bus.result_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign run = (state_q == RUN);

  assign cell_func = run & func_q;
  assign cell_in1  = run & a_sh_q[0];
  assign cell_in2  = run & b_sh_q[0];
  assign cell_in3  = run & cob_q;

  assign bus.start_ready  = (state_q == IDLE) && !rst;
  assign bus.result_valid = (state_q == DONE);
  assign bus.result       = (state_q == DONE) ? res_sh_q : '0;
  assign bus.carry_out    = carry_q;
  assign bus.overflow     = ovf_q;

  assign state_o = state_q;

endmodule
